// File: rtl/ddr_write_issuer_if.sv
// DDR controller write port: AW, W and B channels.
// master = issuer side, slave = controller side.
interface ddr_write_issuer_if #(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 8,
  parameter int DATA_W = 512
);
  logic              awvalid;
  logic              awready;
  logic [ADDR_W-1:0] awaddr;
  logic [LEN_W-1:0]  awlen;
  logic              wvalid;
  logic              wready;
  logic [DATA_W-1:0] wdata;
  logic              wlast;
  logic              bvalid;
  logic              bready;
  logic [1:0]        bresp;

  modport master (
    output awvalid, awaddr, awlen,
    output wvalid, wdata, wlast, bready,
    input  awready, wready, bvalid, bresp
  );

  modport slave (
    input  awvalid, awaddr, awlen,
    input  wvalid, wdata, wlast, bready,
    output awready, wready, bvalid, bresp
  );
endinterface

// File: rtl/ddr_write_issuer.sv
// Pops write descriptors and issues one AW+W burst each to DDR.
// Optional DDR_WR_RESP_CHECK_EN: sticky err on bad/stray B responses.
module ddr_write_issuer #(
  parameter int ADDR_W          = 32,
  parameter int LEN_W           = 8,
  parameter int DATA_W          = 512,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            info_empty,
  output logic                            info_rd_en,
  input  logic [ADDR_W-1:0]               info_addr,
  input  logic [LEN_W-1:0]                info_len,
  input  logic                            s_wvalid,
  output logic                            s_wready,
  input  logic [DATA_W-1:0]               s_wdata,
  ddr_write_issuer_if.master              ddr,
  output logic [$clog2(MAX_OUTSTANDING):0] outstanding,
  output logic [31:0]                     done_cnt,
  output logic                            busy,
  output logic                            err
);
  localparam int OUT_W = $clog2(MAX_OUTSTANDING) + 1;

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] POP  = 3'd1;
  localparam logic [2:0] LOAD = 3'd2;
  localparam logic [2:0] ADDR = 3'd3;
  localparam logic [2:0] DATA = 3'd4;

  logic [2:0]        state;
  logic [2:0]        state_nx;
  logic [LEN_W-1:0]  beat;
  logic [ADDR_W-1:0] awaddr_q;
  logic [LEN_W-1:0]  awlen_q;
  logic              bready_q;
  logic              aw_hs;
  logic              w_hs;
  logic              b_hs;
  logic              b_ok;

  assign aw_hs = ddr.awvalid && ddr.awready;
  assign w_hs  = ddr.wvalid && ddr.wready;
  assign b_hs  = ddr.bvalid && ddr.bready;
  assign b_ok  = b_hs && (outstanding != '0);

  assign info_rd_en  = (state == POP);
  assign ddr.awvalid = (state == ADDR);
  assign ddr.awaddr  = awaddr_q;
  assign ddr.awlen   = awlen_q;
  assign ddr.wvalid  = (state == DATA) && s_wvalid;
  assign s_wready    = (state == DATA) && ddr.wready;
  assign ddr.wdata   = s_wdata;
  assign ddr.wlast   = (state == DATA) && (beat == awlen_q);
  assign ddr.bready  = bready_q;
  assign busy        = (state != IDLE) || (outstanding != '0);

  always_comb begin
    state_nx = state;
    unique case (1'b1)
      state == IDLE:
        if (!info_empty && outstanding < OUT_W'(MAX_OUTSTANDING))
          state_nx = POP;
      state == POP:  state_nx = LOAD;
      state == LOAD: state_nx = ADDR;
      state == ADDR: if (aw_hs) state_nx = DATA;
      state == DATA: if (w_hs && ddr.wlast) state_nx = IDLE;
      default:       state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      beat     <= '0;
      awaddr_q <= '0;
      awlen_q  <= '0;
      bready_q <= 1'b0;
    end else begin
      state    <= state_nx;
      bready_q <= 1'b1;
      if (state == LOAD) begin
        awaddr_q <= info_addr;
        awlen_q  <= info_len;
        beat     <= '0;
      end else if (w_hs) begin
        beat <= beat + LEN_W'(1);
      end
    end
  end

  // A stray B (nothing outstanding) neither underflows nor counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding <= '0;
      done_cnt    <= '0;
    end else begin
      if (aw_hs && !b_ok)
        outstanding <= outstanding + OUT_W'(1);
      else if (!aw_hs && b_ok)
        outstanding <= outstanding - OUT_W'(1);
      if (b_ok)
        done_cnt <= done_cnt + 32'd1;
    end
  end

`ifdef DDR_WR_RESP_CHECK_EN
  logic err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_q <= 1'b0;
    else if (b_hs && (ddr.bresp != 2'b00 || outstanding == '0))
      err_q <= 1'b1;
  end

  assign err = err_q;
`else
  logic unused_bresp;

  assign unused_bresp = ^ddr.bresp;
  assign err          = 1'b0;
`endif
endmodule

// File: tb/tb_ddr_write_issuer.sv
// Randomized bench for ddr_write_issuer with a transaction-level model.
// Honours DDR_WR_RESP_CHECK_EN when predicting err.
module tb_ddr_write_issuer;
  localparam int ADDR_W = 32;
  localparam int LEN_W  = 8;
  localparam int DATA_W = 64;
  localparam int MAXO   = 2;
  localparam int OUT_W  = $clog2(MAXO) + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
  } desc_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              info_empty = 1'b1;
  logic              info_rd_en;
  logic [ADDR_W-1:0] info_addr = '0;
  logic [LEN_W-1:0]  info_len = '0;
  logic              s_wvalid = 1'b0;
  logic              s_wready;
  logic [DATA_W-1:0] s_wdata = '0;
  logic [OUT_W-1:0]  outstanding;
  logic [31:0]       done_cnt;
  logic              busy;
  logic              err;

  always #5 clk = ~clk;

  ddr_write_issuer_if #(
    .ADDR_W(ADDR_W), .LEN_W(LEN_W), .DATA_W(DATA_W)
  ) ddr ();

  ddr_write_issuer #(
    .ADDR_W(ADDR_W), .LEN_W(LEN_W), .DATA_W(DATA_W),
    .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .info_empty(info_empty), .info_rd_en(info_rd_en),
    .info_addr(info_addr), .info_len(info_len),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata),
    .ddr(ddr),
    .outstanding(outstanding), .done_cnt(done_cnt),
    .busy(busy), .err(err)
  );

  int errs = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  desc_t fq[$];
  desc_t exp_q[$];

  // Transaction-level model, updated once per cycle at the falling edge.
  int          m_out = 0;
  logic [31:0] m_done = '0;
  bit          m_err = 0;
  bit          in_fl = 0;
  bit          aw_done = 0;
  int          beat = 0;
  int          cur_len = 0;
  int          pop_c = 0;
  int          cyc = 0;
  int          neg_rel = 0;

  always @(negedge clk) begin : monitor
    bit inf, aw_hs, w_hs, b_hs;
    cyc++;
    if (!rst_n) begin
      m_out = 0; m_done = '0; m_err = 0;
      in_fl = 0; aw_done = 0; beat = 0;
      neg_rel = 0;
      exp_q.delete();
    end else begin
      if (info_rd_en) begin
        chk("pop_ok", {in_fl, m_out >= MAXO, fq.size() == 0}, 0);
        pop_c = cyc;
      end
      inf = in_fl || info_rd_en;
      chk("busy", busy, inf || m_out != 0);
      chk("outstanding", outstanding, m_out);
      chk("done_cnt", done_cnt, m_done);
      chk("err", err, m_err);
      chk("bready", ddr.bready, neg_rel >= 1);
      chk("awvalid", ddr.awvalid, in_fl && !aw_done && cyc >= pop_c + 2);
      if (ddr.awvalid) begin
        chk("aw_q", exp_q.size(), 1);
        if (exp_q.size() > 0) begin
          chk("awaddr", ddr.awaddr, exp_q[0].addr);
          chk("awlen", ddr.awlen, exp_q[0].len);
        end
      end
      chk("wvalid", ddr.wvalid, aw_done && s_wvalid);
      chk("s_wready", s_wready, aw_done && ddr.wready);
      chk("wlast", ddr.wlast, aw_done && beat == cur_len);
      if (ddr.wvalid) chk("wdata", ddr.wdata, s_wdata);

      aw_hs = ddr.awvalid && ddr.awready;
      w_hs  = ddr.wvalid && ddr.wready;
      b_hs  = ddr.bvalid && ddr.bready;
`ifdef DDR_WR_RESP_CHECK_EN
      if (b_hs && (ddr.bresp != 2'b00 || m_out == 0)) m_err = 1;
`endif
      if (b_hs && m_out > 0) begin
        m_out--;
        m_done++;
      end
      if (w_hs) begin
        if (beat == cur_len) begin
          in_fl = 0;
          aw_done = 0;
        end else begin
          beat++;
        end
      end
      if (info_rd_en) in_fl = 1;
      if (aw_hs && exp_q.size() > 0) begin
        m_out++;
        aw_done = 1;
        beat = 0;
        cur_len = int'(exp_q[0].len);
        void'(exp_q.pop_front());
      end
      neg_rel++;
    end
  end

  int pops = 0;
  int wbeats = 0;
  int dcyc = 0;
  int pop_dc = -1;
  int wl_c = -1;

  // Advance one cycle; the FIFO model returns data the cycle after a pop.
  task automatic step();
    bit   pop;
    desc_t d;
    #2;
    pop = rst_n && info_rd_en;
    if (pop) pop_dc = dcyc;
    if (rst_n && ddr.wvalid && ddr.wready) begin
      wbeats++;
      if (ddr.wlast) wl_c = dcyc;
    end
    @(posedge clk);
    #1;
    dcyc++;
    if (pop && fq.size() > 0) begin
      d = fq.pop_front();
      info_addr = d.addr;
      info_len  = d.len;
      exp_q.push_back(d);
      pops++;
    end
    info_empty = (fq.size() == 0);
  endtask

  task automatic push(input logic [ADDR_W-1:0] a, input int l);
    desc_t d;
    d.addr = a;
    d.len  = LEN_W'(l);
    fq.push_back(d);
    info_empty = 1'b0;
  endtask

  task automatic rnd();
    ddr.awready = ($urandom_range(0, 3) != 0);
    ddr.wready  = ($urandom_range(0, 3) != 0);
    s_wvalid    = ($urandom_range(0, 3) != 0);
    ddr.bvalid  = ($urandom_range(0, 3) == 0);
    ddr.bresp   = ($urandom_range(0, 15) == 0) ? 2'b10 : 2'b00;
    s_wdata     = {$urandom, $urandom};
  endtask

  task automatic all_ready();
    ddr.awready = 1'b1;
    ddr.wready  = 1'b1;
    s_wvalid    = 1'b1;
    ddr.bresp   = 2'b00;
  endtask

  task automatic reset_checks(input string p);
    chk({p, "_rd_en"}, info_rd_en, 0);
    chk({p, "_awvalid"}, ddr.awvalid, 0);
    chk({p, "_wvalid"}, ddr.wvalid, 0);
    chk({p, "_wlast"}, ddr.wlast, 0);
    chk({p, "_s_wready"}, s_wready, 0);
    chk({p, "_bready"}, ddr.bready, 0);
    chk({p, "_busy"}, busy, 0);
    chk({p, "_err"}, err, 0);
    chk({p, "_awaddr"}, ddr.awaddr, 0);
    chk({p, "_awlen"}, ddr.awlen, 0);
    chk({p, "_outst"}, outstanding, 0);
    chk({p, "_done"}, done_cnt, 0);
  endtask

  task automatic drain(input string p);
    int n = 0;
    while ((fq.size() != 0 || busy) && n < 3000) begin
      rnd();
      ddr.bvalid = 1'b1;
      step();
      n++;
    end
    chk({p, "_timeout"}, n < 3000, 1);
  endtask

  initial begin
    ddr.awready = 1'b0;
    ddr.wready  = 1'b0;
    ddr.bvalid  = 1'b0;
    ddr.bresp   = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    reset_checks("por");
    rst_n = 1'b1;

    // Single beat, all ready: pop t, last beat t+3.
    all_ready();
    ddr.bvalid = 1'b0;
    push(32'h1000, 0);
    repeat (10) step();
    chk("single_lat", wl_c - pop_dc, 3);
    ddr.bvalid = 1'b1;
    step();
    ddr.bvalid = 1'b0;
    chk("single_outst", outstanding, 0);
    chk("single_done", done_cnt, 1);

    // Outstanding limit with no responses returned.
    pops = 0;
    for (int i = 0; i < 5; i++) push($urandom, 0);
    repeat (40) step();
    chk("lim_pops", pops, 2);
    chk("lim_outst", outstanding, 2);
    ddr.bvalid = 1'b1;
    step();
    ddr.bvalid = 1'b0;
    repeat (20) step();
    chk("lim_pops3", pops, 3);
    chk("lim_outst3", outstanding, 2);

    repeat (3000) begin
      rnd();
      if ($urandom_range(0, 7) == 0 && fq.size() < 4)
        push($urandom, $urandom_range(0, 7));
      step();
    end
    drain("drain1");

    // Reset asserted in the middle of a len-7 burst.
    all_ready();
    ddr.bvalid = 1'b0;
    push($urandom, 7);
    wbeats = 0;
    for (int n = 0; n < 50 && wbeats < 2; n++) step();
    chk("mid_beats", wbeats, 2);
    rst_n = 1'b0;
    #1;
    reset_checks("mid");
    step();
    step();
    rst_n = 1'b1;
    pops = 0;
    push(32'h2000, 1);
    repeat (15) step();
    chk("post_pops", pops, 1);
    drain("drain2");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
